// File: rtl/prog_uart_tx.sv
// prog_uart_tx: 8N1 UART transmitter with a small push FIFO.
// Bytes are pushed over a valid/ready port, queued, and serialised LSB first
// on io_tx_o. The bit period is latched from io_CLK_PER_BIT at each frame start.
module prog_uart_tx #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               io_tx_data_i,
  input  logic                     io_tx_valid_i,
  output logic                     io_tx_ready_o,
  input  logic [15:0]              io_CLK_PER_BIT,
  output logic                     io_tx_o,
  output logic                     io_busy_o,
  output logic [$clog2(DEPTH):0]   io_fifo_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      shift_q, shift_d;
  logic [15:0]     period_q, period_d;
  logic [15:0]     cyc_q, cyc_d;
  logic [2:0]      bit_q, bit_d;
  logic            push, pop, bit_done, fifo_empty, fifo_full;
  logic [15:0]     period_clamped;

  assign fifo_full      = (count_q == CW'(DEPTH));
  assign fifo_empty     = (count_q == '0);
  // A pop in the same cycle does not make room: fullness uses the registered count.
  assign push           = io_tx_valid_i && !fifo_full;
  assign bit_done       = (cyc_q == period_q - 16'd1);
  assign period_clamped = (io_CLK_PER_BIT < 16'd2) ? 16'd2 : io_CLK_PER_BIT;

  // FIFO storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= io_tx_data_i;
    end
  end

  // FIFO pointers/occupancy plus all FSM datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      shift_q  <= 8'hFF;
      period_q <= 16'd2;
      cyc_q    <= '0;
      bit_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      period_q <= period_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
    end
  end

  // Occupancy: push and pop together leave the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Next-state logic: frame sequencing, FIFO pop and per-frame period latch.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    shift_d  = shift_q;
    period_d = period_q;
    cyc_d    = cyc_q + 16'd1;
    bit_d    = bit_q;
    case (state_q)
      IDLE: begin
        cyc_d = cyc_q;
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_d  = START;
          shift_d  = mem_q[rd_ptr_q];
          period_d = period_clamped;
          cyc_d    = '0;
          bit_d    = '0;
        end
      end
      START: begin
        if (bit_done) begin
          cyc_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          cyc_d   = '0;
          shift_d = {1'b1, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          // Bit counter wrapping from 7 ends the data phase.
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          cyc_d = '0;
          if (!fifo_empty) begin
            // Back-to-back frame: no idle gap between stop and next start.
            pop      = 1'b1;
            state_d  = START;
            shift_d  = mem_q[rd_ptr_q];
            period_d = period_clamped;
            bit_d    = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registers only.
  always_comb begin
    io_tx_o = 1'b1;
    case (state_q)
      START:   io_tx_o = 1'b0;
      DATA:    io_tx_o = shift_q[0];
      default: io_tx_o = 1'b1;
    endcase
    io_busy_o       = (state_q != IDLE) || !fifo_empty;
    io_tx_ready_o   = !fifo_full;
    io_fifo_count_o = count_q;
  end

endmodule

// File: tb/tb_prog_uart_tx.sv
// Testbench for prog_uart_tx: frame-level reference model, per-cycle line
// checks and a byte scoreboard fed from a line decoder.
module tb_prog_uart_tx;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data  = 8'h00;
  logic        valid = 1'b0;
  logic [15:0] cpb   = 16'd4;
  logic        ready, tx, busy;
  logic [2:0]  cnt;

  int cmp_n = 0;
  int err_n = 0;

  always #5 clock = ~clock;

  prog_uart_tx #(.DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .io_tx_data_i    (data),
    .io_tx_valid_i   (valid),
    .io_tx_ready_o   (ready),
    .io_CLK_PER_BIT  (cpb),
    .io_tx_o         (tx),
    .io_busy_o       (busy),
    .io_fifo_count_o (cnt)
  );

  // Reference model state
  logic [7:0] mq[$];    // bytes waiting in the FIFO
  logic [7:0] sbq[$];   // bytes expected on the line, in order
  int         cyc = 0;
  bit         m_in = 0;
  int         m_start = 0;
  int         m_p = 2;
  logic [7:0] m_byte = 8'h00;
  logic       exp_tx = 1'b1, exp_ready = 1'b1, exp_busy = 1'b0;
  int         exp_cnt = 0;
  bit         started = 0;
  bit         mon_abort = 0;

  task automatic chk(input string name, input int act, input int req);
    cmp_n++;
    if (act != req) begin
      err_n++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Frame-level model: a frame popped at edge S occupies 10*P edges, P = max(cpb,2).
  initial begin : model
    int  sz;
    int  k;
    bit  do_push;
    forever begin
      @(posedge clock);
      cyc++;
      if (reset) begin
        mq.delete();
        sbq.delete();
        m_in = 0;
        mon_abort = 1;
      end else begin
        sz = mq.size();
        do_push = valid && (sz != DEPTH);
        if (m_in && (cyc == m_start + 10 * m_p)) m_in = 0;
        if (!m_in && sz != 0) begin
          m_byte  = mq.pop_front();
          m_in    = 1;
          m_start = cyc;
          m_p     = (cpb < 16'd2) ? 2 : int'(cpb);
        end
        if (do_push) begin
          mq.push_back(data);
          sbq.push_back(data);
        end
      end
      exp_tx = 1'b1;
      if (m_in) begin
        k = (cyc - m_start) / m_p;
        if (k == 0)      exp_tx = 1'b0;
        else if (k <= 8) exp_tx = m_byte[k-1];
      end
      exp_cnt   = mq.size();
      exp_ready = (mq.size() != DEPTH);
      exp_busy  = m_in || (mq.size() != 0);
      started   = 1;
    end
  end

  // Monitor: per-cycle output checks, and a line decoder that pops the scoreboard.
  initial begin : monitor
    int         s;
    int         mp;
    bit         act;
    logic [7:0] dec;
    logic [7:0] want;
    s = 0; mp = 2; act = 0; dec = 8'h00;
    forever begin
      @(negedge clock);
      if (started) begin
        chk("tx",    int'(tx),    int'(exp_tx));
        chk("ready", int'(ready), int'(exp_ready));
        chk("busy",  int'(busy),  int'(exp_busy));
        chk("count", int'(cnt),   exp_cnt);
      end
      if (mon_abort) begin
        act = 0;
        mon_abort = 0;
      end else if (act) begin
        s++;
        if ((s % mp) == (mp / 2) && (s / mp) >= 1 && (s / mp) <= 8)
          dec[(s / mp) - 1] = tx;
        if (s == 10 * mp - 1) begin
          act = 0;
          cmp_n++;
          if (sbq.size() == 0) begin
            err_n++;
            $display("FAIL frame cyc=%0d actual=%02h required=none", cyc, dec);
          end else begin
            want = sbq.pop_front();
            $display("frame P=%0d got %02h want %02h", mp, dec, want);
            if (dec != want) begin
              err_n++;
              $display("FAIL frame cyc=%0d actual=%02h required=%02h", cyc, dec, want);
            end
          end
        end
      end else if (started && tx == 1'b0) begin
        act = 1;
        s   = 0;
        mp  = m_p;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves valid high; caller drops it when the burst is over.
  task automatic push_byte(input logic [7:0] b);
    bit ok;
    ok = 0;
    data  = b;
    valid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clock);
      ok = ready;
      tick();
    end
    if (!ok) begin
      cmp_n++;
      err_n++;
      $display("FAIL push_timeout actual=not_accepted required=accepted byte=%02h", b);
    end
  endtask

  task automatic wait_idle(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clock);
      if (!busy) break;
    end
    if (i == limit) begin
      cmp_n++;
      err_n++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  initial begin : stimulus
    // 1: reset held for three cycles
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();

    // 2: single byte at P=4
    cpb = 16'd4;
    push_byte(8'hA5);
    valid = 1'b0;
    wait_idle(200);
    tick();

    // 3: continuous valid at P=8, back-to-back frames
    cpb = 16'd8;
    for (int i = 0; i < 8; i++) push_byte(8'(i));
    valid = 1'b0;
    wait_idle(2000);
    tick();

    // 4: period change during data bit 3 applies only to the next frame
    cpb = 16'd4;
    push_byte(8'h3C);
    push_byte(8'hC3);
    valid = 1'b0;
    repeat (17) tick();
    cpb = 16'd6;
    wait_idle(500);
    tick();

    // 5: reset during data bit 5 with three bytes queued
    cpb = 16'd4;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    valid = 1'b0;
    repeat (23) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (30) tick();

    // 6: period 0 clamps to 2
    cpb = 16'd0;
    push_byte(8'hFF);
    valid = 1'b0;
    wait_idle(100);
    tick();

    // Random traffic, period changes and occasional resets
    for (int i = 0; i < 3000; i++) begin
      valid = ($urandom_range(0, 3) == 0);
      data  = 8'($urandom);
      if ($urandom_range(0, 199) == 0) cpb = 16'($urandom_range(0, 9));
      reset = ($urandom_range(0, 1499) == 0);
      tick();
    end
    valid = 1'b0;
    reset = 1'b0;
    wait_idle(3000);
    repeat (2) tick();
    chk("drain", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
